fetch_sequencer: RTL and testbench

- Dual-issue fetch controller for the interleaved two-bank program ROM.
- Holds the halfword PC and drives the ROM address, the bank-offset bit and the two output-mux selects, so that slot 0 carries the instruction at PC and slot 1 the instruction at PC+1.
- Advances the PC by the number of instructions decode consumed.
- Handles branch redirect with a one-cycle bubble, stalls, halt and end-of-program.

---
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Dual-issue fetch controller for the interleaved two-bank program ROM.
// Holds the halfword PC, steers both ROM banks into two issue slots and tracks retirement.
module fetch_sequencer #(
    parameter logic [14:0] RESET_PC = 15'h0000,
    parameter logic [14:0] PROG_END = 15'h001A,
    parameter bit          DUAL_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  consume,
    input  logic        stall,
    input  logic        branch_valid,
    input  logic [14:0] branch_target,
    input  logic        halt_req,
    output logic [13:0] Rom_addr_in,
    output logic        pc_1,
    output logic        sel_mem_1,
    output logic [1:0]  sel_mem_0,
    output logic [14:0] fetch_pc,
    output logic        valid_0,
    output logic        valid_1,
    output logic [15:0] retired,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [14:0] pc_r;
    logic [14:0] pc_s;
    logic [15:0] retired_r;
    logic [15:0] retired_s;
    logic        err_r;
    logic        err_s;
    logic        valid_0_r;
    logic        valid_1_r;
    logic [1:0]  valid_s;
    logic [1:0]  avail_s;
    logic        bad_consume_s;
    logic [16:0] retire_sum_s;

    // Slot validity for a given state and PC; pc+1 is widened so 0x7FFF cannot wrap into range.
    function automatic logic [1:0] slot_valid(input state_t st, input logic [14:0] pc);
        logic [1:0] v;
        if (st == ST_RUN) begin
            v[0] = (pc <= PROG_END);
            v[1] = DUAL_EN && (({1'b0, pc} + 16'd1) <= {1'b0, PROG_END}) && (pc != 15'h7FFF);
        end else begin
            v = 2'b00;
        end
        return v;
    endfunction

    // Next-state, next-PC, retirement and error evaluation.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        retired_s     = retired_r;
        err_s         = err_r;
        avail_s       = {1'b0, valid_0_r} + {1'b0, valid_1_r};
        bad_consume_s = (consume == 2'd3) || (consume > avail_s);
        retire_sum_s  = {1'b0, retired_r} + {15'd0, consume};

        if ((state_r == ST_RUN) && !stall) begin
            if (bad_consume_s) begin
                err_s = 1'b1;
            end else begin
                retired_s = retire_sum_s[16] ? 16'hFFFF : retire_sum_s[15:0];
            end
        end else begin
            err_s = err_r;
        end

        case (state_r)
            ST_BOOT: begin
                state_s = ST_RUN;
            end
            ST_RUN, ST_FLUSH: begin
                if (branch_valid) begin
                    pc_s    = branch_target;
                    state_s = ST_FLUSH;
                end else if (halt_req) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_RUN;
                    if ((state_r == ST_RUN) && !stall && !bad_consume_s) begin
                        pc_s = pc_r + {13'd0, consume};
                    end else begin
                        pc_s = pc_r;
                    end
                end
            end
            ST_HALT: begin
                if (branch_valid) begin
                    pc_s    = branch_target;
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_BOOT;
            end
        endcase

        valid_s = slot_valid(state_s, pc_s);
    end

    // State, PC, counters and slot-valid registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_BOOT;
            pc_r      <= RESET_PC;
            retired_r <= 16'd0;
            err_r     <= 1'b0;
            valid_0_r <= 1'b0;
            valid_1_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            pc_r      <= pc_s;
            retired_r <= retired_s;
            err_r     <= err_s;
            valid_0_r <= valid_s[0];
            valid_1_r <= valid_s[1];
        end
    end

    // Odd PC puts slot 0 in bank 1 and slot 1 in bank 0 of the next row.
    assign Rom_addr_in = pc_r[14:1];
    assign pc_1        = pc_r[0];
    assign sel_mem_1   = ~pc_r[0];
    assign sel_mem_0   = pc_r[0] ? 2'd2 : 2'd0;
    assign fetch_pc    = pc_r;
    assign valid_0     = valid_0_r;
    assign valid_1     = valid_1_r;
    assign retired     = retired_r;
    assign err         = err_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: table-driven steps, expected results queued per step.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  consume = 2'd0;
    logic        stall = 1'b0;
    logic        branch_valid = 1'b0;
    logic [14:0] branch_target = 15'd0;
    logic        halt_req = 1'b0;

    logic [13:0] rom_addr;
    logic        pc_1;
    logic        sel_mem_1;
    logic [1:0]  sel_mem_0;
    logic [14:0] fetch_pc;
    logic        valid_0;
    logic        valid_1;
    logic [15:0] retired;
    logic        err;

    logic [13:0] w_rom_addr;
    logic        w_pc_1;
    logic        w_sel_mem_1;
    logic [1:0]  w_sel_mem_0;
    logic [14:0] w_fetch_pc;
    logic        w_valid_0;
    logic        w_valid_1;
    logic [15:0] w_retired;
    logic        w_err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rst;
        logic [1:0]  cons;
        logic        stall;
        logic        br;
        logic [14:0] tgt;
        logic        halt;
        logic [14:0] pc;
        logic        v0;
        logic        v1;
        logic [15:0] ret;
        logic        err;
    } step_t;

    step_t sb[$];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .consume(consume), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target), .halt_req(halt_req),
        .Rom_addr_in(rom_addr), .pc_1(pc_1), .sel_mem_1(sel_mem_1), .sel_mem_0(sel_mem_0),
        .fetch_pc(fetch_pc), .valid_0(valid_0), .valid_1(valid_1), .retired(retired), .err(err)
    );

    // Second instance whose program spans the whole address space, for the wrap scenario.
    fetch_sequencer #(.PROG_END(15'h7FFF)) dut_w (
        .clk(clk), .rst(rst), .consume(consume), .stall(stall),
        .branch_valid(branch_valid), .branch_target(branch_target), .halt_req(halt_req),
        .Rom_addr_in(w_rom_addr), .pc_1(w_pc_1), .sel_mem_1(w_sel_mem_1), .sel_mem_0(w_sel_mem_0),
        .fetch_pc(w_fetch_pc), .valid_0(w_valid_0), .valid_1(w_valid_1), .retired(w_retired), .err(w_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input step_t s);
        rst           = s.rst;
        consume       = s.cons;
        stall         = s.stall;
        branch_valid  = s.br;
        branch_target = s.tgt;
        halt_req      = s.halt;
        sb.push_back(s);
        @(posedge clk);
        #1;
        rst = 1'b0; consume = 2'd0; stall = 1'b0; branch_valid = 1'b0; halt_req = 1'b0;
    endtask

    task automatic test_reset();
        step_t e;
        step_t tbl [3] = '{
            '{1'b1, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'd0, 1'b0},
            '{1'b1, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'd0, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b1, 15'h0005, 1'b1, 15'h0000, 1'b1, 1'b1, 16'd0, 1'b0}
        };
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({fetch_pc, valid_0, valid_1, retired, err} !== {e.pc, e.v0, e.v1, e.ret, e.err}) begin
                errors++;
                $display("FAIL reset[%0d]: got pc=%h v=%b%b ret=%0d err=%b, want pc=%h v=%b%b ret=%0d err=%b",
                         i, fetch_pc, valid_0, valid_1, retired, err, e.pc, e.v0, e.v1, e.ret, e.err);
            end
        end
    endtask

    task automatic test_run_aligned();
        step_t e;
        step_t tbl [2] = '{
            '{1'b0, 2'd2, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0002, 1'b1, 1'b1, 16'd2, 1'b0},
            '{1'b0, 2'd2, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0004, 1'b1, 1'b1, 16'd4, 1'b0}
        };
        for (int i = 0; i < 2; i++) begin
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({fetch_pc, valid_0, valid_1, retired, err} !== {e.pc, e.v0, e.v1, e.ret, e.err}) begin
                errors++;
                $display("FAIL run_aligned[%0d]: got pc=%h v=%b%b ret=%0d err=%b, want pc=%h v=%b%b ret=%0d err=%b",
                         i, fetch_pc, valid_0, valid_1, retired, err, e.pc, e.v0, e.v1, e.ret, e.err);
            end
            checks++;
            if ({rom_addr, pc_1, sel_mem_1, sel_mem_0} !== {14'(i + 1), 1'b0, 1'b1, 2'd0}) begin
                errors++;
                $display("FAIL run_aligned_addr[%0d]: got rom=%0d pc_1=%b s1=%b s0=%0d, want rom=%0d pc_1=0 s1=1 s0=0",
                         i, rom_addr, pc_1, sel_mem_1, sel_mem_0, i + 1);
            end
        end
    endtask

    task automatic test_branch();
        step_t e;
        step_t tbl [7] = '{
            '{1'b0, 2'd2, 1'b0, 1'b1, 15'h000B, 1'b0, 15'h000B, 1'b0, 1'b0, 16'd6, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h000B, 1'b1, 1'b1, 16'd6, 1'b0},
            '{1'b0, 2'd2, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h000D, 1'b1, 1'b1, 16'd8, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b1, 15'h0010, 1'b0, 15'h0010, 1'b0, 1'b0, 16'd8, 1'b0},
            '{1'b0, 2'd2, 1'b0, 1'b1, 15'h0014, 1'b0, 15'h0014, 1'b0, 1'b0, 16'd8, 1'b0},
            '{1'b0, 2'd2, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0014, 1'b1, 1'b1, 16'd8, 1'b0},
            '{1'b0, 2'd1, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0015, 1'b1, 1'b1, 16'd9, 1'b0}
        };
        for (int i = 0; i < 7; i++) begin
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({fetch_pc, valid_0, valid_1, retired, err} !== {e.pc, e.v0, e.v1, e.ret, e.err}) begin
                errors++;
                $display("FAIL branch[%0d]: got pc=%h v=%b%b ret=%0d err=%b, want pc=%h v=%b%b ret=%0d err=%b",
                         i, fetch_pc, valid_0, valid_1, retired, err, e.pc, e.v0, e.v1, e.ret, e.err);
            end
        end
    endtask

    task automatic test_odd_alignment();
        step_t e;
        step_t tbl [3] = '{
            '{1'b1, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'd0, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 1'b1, 16'd0, 1'b0},
            '{1'b0, 2'd1, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0001, 1'b1, 1'b1, 16'd1, 1'b0}
        };
        for (int i = 0; i < 3; i++) begin
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({fetch_pc, valid_0, valid_1, retired, err} !== {e.pc, e.v0, e.v1, e.ret, e.err}) begin
                errors++;
                $display("FAIL odd[%0d]: got pc=%h v=%b%b ret=%0d err=%b, want pc=%h v=%b%b ret=%0d err=%b",
                         i, fetch_pc, valid_0, valid_1, retired, err, e.pc, e.v0, e.v1, e.ret, e.err);
            end
        end
        checks++;
        if ({rom_addr, pc_1, sel_mem_1, sel_mem_0} !== {14'd0, 1'b1, 1'b0, 2'd2}) begin
            errors++;
            $display("FAIL odd_addr: got rom=%0d pc_1=%b s1=%b s0=%0d, want rom=0 pc_1=1 s1=0 s0=2",
                     rom_addr, pc_1, sel_mem_1, sel_mem_0);
        end
    endtask

    task automatic test_end_of_program();
        step_t e;
        step_t tbl [6] = '{
            '{1'b0, 2'd0, 1'b0, 1'b1, 15'h001A, 1'b0, 15'h001A, 1'b0, 1'b0, 16'd1, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h001A, 1'b1, 1'b0, 16'd1, 1'b0},
            '{1'b0, 2'd2, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h001A, 1'b1, 1'b0, 16'd1, 1'b1},
            '{1'b0, 2'd1, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h001B, 1'b0, 1'b0, 16'd2, 1'b1},
            '{1'b0, 2'd1, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h001B, 1'b0, 1'b0, 16'd2, 1'b1},
            '{1'b0, 2'd3, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h001B, 1'b0, 1'b0, 16'd2, 1'b1}
        };
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({fetch_pc, valid_0, valid_1, retired, err} !== {e.pc, e.v0, e.v1, e.ret, e.err}) begin
                errors++;
                $display("FAIL end_of_program[%0d]: got pc=%h v=%b%b ret=%0d err=%b, want pc=%h v=%b%b ret=%0d err=%b",
                         i, fetch_pc, valid_0, valid_1, retired, err, e.pc, e.v0, e.v1, e.ret, e.err);
            end
        end
    endtask

    task automatic test_stall_halt();
        step_t e;
        step_t tbl [9] = '{
            '{1'b1, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'd0, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 1'b1, 16'd0, 1'b0},
            '{1'b0, 2'd2, 1'b1, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 1'b1, 16'd0, 1'b0},
            '{1'b0, 2'd3, 1'b1, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 1'b1, 16'd0, 1'b0},
            '{1'b0, 2'd2, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0002, 1'b1, 1'b1, 16'd2, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b1, 15'h0002, 1'b0, 1'b0, 16'd2, 1'b0},
            '{1'b0, 2'd2, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0002, 1'b0, 1'b0, 16'd2, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b1, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'd2, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 1'b1, 16'd2, 1'b0}
        };
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({fetch_pc, valid_0, valid_1, retired, err} !== {e.pc, e.v0, e.v1, e.ret, e.err}) begin
                errors++;
                $display("FAIL stall_halt[%0d]: got pc=%h v=%b%b ret=%0d err=%b, want pc=%h v=%b%b ret=%0d err=%b",
                         i, fetch_pc, valid_0, valid_1, retired, err, e.pc, e.v0, e.v1, e.ret, e.err);
            end
        end
    endtask

    task automatic test_wrap_reset();
        step_t e;
        step_t tbl [8] = '{
            '{1'b1, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 16'd0, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 1'b1, 16'd0, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b1, 15'h7FFE, 1'b0, 15'h7FFE, 1'b0, 1'b0, 16'd0, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h7FFE, 1'b1, 1'b1, 16'd0, 1'b0},
            '{1'b0, 2'd2, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 1'b1, 16'd2, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b1, 15'h7FFF, 1'b0, 15'h7FFF, 1'b0, 1'b0, 16'd2, 1'b0},
            '{1'b0, 2'd0, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h7FFF, 1'b1, 1'b0, 16'd2, 1'b0},
            '{1'b0, 2'd1, 1'b0, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b1, 1'b1, 16'd3, 1'b0}
        };
        step_t rst_step = '{1'b1, 2'd2, 1'b0, 1'b1, 15'h0055, 1'b0, 15'h0000, 1'b0, 1'b0, 16'd0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i]);
            e = sb.pop_front();
            checks++;
            if ({w_fetch_pc, w_valid_0, w_valid_1, w_retired, w_err} !== {e.pc, e.v0, e.v1, e.ret, e.err}) begin
                errors++;
                $display("FAIL wrap[%0d]: got pc=%h v=%b%b ret=%0d err=%b, want pc=%h v=%b%b ret=%0d err=%b",
                         i, w_fetch_pc, w_valid_0, w_valid_1, w_retired, w_err, e.pc, e.v0, e.v1, e.ret, e.err);
            end
        end
        // The short-program instance consumed past its end above, so its sticky error must be set.
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_before_reset: got err=%b, want 1", err);
        end
        drive(rst_step);
        e = sb.pop_front();
        checks++;
        if ({w_fetch_pc, w_valid_0, w_valid_1, w_retired, w_err} !== {e.pc, e.v0, e.v1, e.ret, e.err}) begin
            errors++;
            $display("FAIL reset_over_branch_w: got pc=%h v=%b%b ret=%0d err=%b, want pc=%h v=00 ret=0 err=0",
                     w_fetch_pc, w_valid_0, w_valid_1, w_retired, w_err, e.pc);
        end
        checks++;
        if ({fetch_pc, valid_0, valid_1, retired, err} !== {e.pc, e.v0, e.v1, e.ret, e.err}) begin
            errors++;
            $display("FAIL reset_over_branch: got pc=%h v=%b%b ret=%0d err=%b, want pc=%h v=00 ret=0 err=0",
                     fetch_pc, valid_0, valid_1, retired, err, e.pc);
        end
    endtask

    initial begin
        test_reset();
        test_run_aligned();
        test_branch();
        test_odd_alignment();
        test_end_of_program();
        test_stall_halt();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
